// File: rtl/dpot_spi_if.sv
// rtl/dpot_spi_if.sv - 3-wire pot load link (ResCS/ResClk/ResSDI) plus readback line
interface dpot_spi_if;
    logic ResCS;
    logic ResClk;
    logic ResSDI;
    logic ResSDO;

    modport master (output ResCS, output ResClk, output ResSDI, input ResSDO);
    modport slave  (input ResCS, input ResClk, input ResSDI, output ResSDO);
endinterface

// File: rtl/dpot_spi_responder.sv
// rtl/dpot_spi_responder.sv - oversampling digital-pot frame receiver with per-channel wiper registers
// Optional wiper readback on ResSDO when DPOT_READBACK_EN is defined.
module dpot_spi_responder #(
    parameter int                NUM_CH    = 8,
    parameter int                ADDR_W    = 3,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] WIPER_RST = 8'h80
) (
    input  logic                       clk_out1,
    input  logic                       Rst_n,
    dpot_spi_if.slave                  spi,
    output logic [NUM_CH*DATA_W-1:0]   wiper_bus,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       frame_err,
    output logic                       busy
);
    localparam int          FRM_W     = ADDR_W + DATA_W;
    localparam logic [3:0]  FRAME_LEN = 4'(FRM_W);

    typedef enum logic [1:0] {IDLE, SHIFT, CLOSE} state_t;

    state_t                      state_q;
    logic [2:0]                  cs_q, sck_q;
    logic [1:0]                  sdi_q;
    logic [FRM_W-1:0]            shift_q;
    logic [3:0]                  cnt_q;
    logic [NUM_CH*DATA_W-1:0]    wiper_q;
    logic                        wr_stb_q, frame_err_q;
    logic [ADDR_W-1:0]           wr_addr_q;
    logic [DATA_W-1:0]           wr_data_q;

    logic                        cs_rise, cs_fall, sck_rise, sdi_s;
    logic [ADDR_W-1:0]           fr_addr;
    logic [DATA_W-1:0]           fr_data;
    logic                        frame_ok;

    // Stage 1 is [0], stage 2 is [1], history is [2]; edges compare stages 2 and 3.
    always_ff @(posedge clk_out1 or negedge Rst_n) begin
        if (!Rst_n) begin
            cs_q  <= 3'b111;
            sck_q <= 3'b000;
            sdi_q <= 2'b00;
        end else begin
            cs_q  <= {cs_q[1:0], spi.ResCS};
            sck_q <= {sck_q[1:0], spi.ResClk};
            sdi_q <= {sdi_q[0], spi.ResSDI};
        end
    end

    assign cs_rise  =  cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] &  cs_q[2];
    assign sck_rise =  sck_q[1] & ~sck_q[2];
    assign sdi_s    =  sdi_q[1];

    assign fr_addr  = shift_q[FRM_W-1 -: ADDR_W];
    assign fr_data  = shift_q[DATA_W-1:0];
    assign frame_ok = (cnt_q == FRAME_LEN) && ({1'b0, fr_addr} < (ADDR_W+1)'(NUM_CH));

    always_ff @(posedge clk_out1 or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            wiper_q     <= {NUM_CH{WIPER_RST}};
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end
                end
                SHIFT: begin
                    // A closing CS takes priority: a coincident clock edge is dropped.
                    if (cs_rise) begin
                        state_q <= CLOSE;
                    end else if (sck_rise) begin
                        shift_q <= {shift_q[FRM_W-2:0], sdi_s};
                        if (cnt_q != 4'hF) cnt_q <= cnt_q + 4'd1;
                    end
                end
                CLOSE: begin
                    if (frame_ok) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                            if (fr_addr == ADDR_W'(n)) wiper_q[n*DATA_W +: DATA_W] <= fr_data;
                        end
                        wr_addr_q <= fr_addr;
                        wr_data_q <= fr_data;
                        wr_stb_q  <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shift_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DPOT_READBACK_EN
    localparam logic [3:0] ADDR_LAST = 4'(ADDR_W - 1);
    localparam logic [3:0] DATA_LAST = 4'(FRM_W - 1);

    logic [DATA_W-1:0] rb_q;
    logic              rb_on_q, sdo_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    // Address as it will stand once the bit arriving on this edge is shifted in.
    assign rd_addr = ADDR_W'({shift_q, sdi_s});

    always_comb begin
        rd_word = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (rd_addr == ADDR_W'(n)) rd_word = wiper_q[n*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_out1 or negedge Rst_n) begin
        if (!Rst_n) begin
            rb_q    <= '0;
            rb_on_q <= 1'b0;
            sdo_q   <= 1'b0;
        end else if (state_q == SHIFT && !cs_rise && sck_rise) begin
            if (cnt_q == ADDR_LAST) begin
                if ({1'b0, rd_addr} < (ADDR_W+1)'(NUM_CH)) begin
                    rb_q    <= {rd_word[DATA_W-2:0], 1'b0};
                    sdo_q   <= rd_word[DATA_W-1];
                    rb_on_q <= 1'b1;
                end else begin
                    sdo_q   <= 1'b0;
                    rb_on_q <= 1'b0;
                end
            end else if (rb_on_q && cnt_q < DATA_LAST) begin
                sdo_q <= rb_q[DATA_W-1];
                rb_q  <= {rb_q[DATA_W-2:0], 1'b0};
            end else begin
                sdo_q   <= 1'b0;
                rb_on_q <= 1'b0;
            end
        end else if (state_q != SHIFT) begin
            sdo_q   <= 1'b0;
            rb_on_q <= 1'b0;
        end
    end

    assign spi.ResSDO = sdo_q;
`else
    assign spi.ResSDO = 1'b0;
`endif

    assign wiper_bus = wiper_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);
endmodule

// File: tb/tb_dpot_spi_responder.sv
// tb/tb_dpot_spi_responder.sv - scoreboard bench for dpot_spi_responder
`timescale 1ns/1ps
module tb_dpot_spi_responder;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] wiper_bus;
    logic        wr_stb, frame_err, busy;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    always #5 clk = ~clk;

    dpot_spi_if sif();

    dpot_spi_responder dut (
        .clk_out1 (clk),
        .Rst_n    (rst_n),
        .spi      (sif),
        .wiper_bus(wiper_bus),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    typedef struct packed {
        logic       err;
        logic [2:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] model[8];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int nbits, input logic [31:0] v, input bit cs_last,
                        output logic [31:0] cap);
        cap = '0;
        sif.ResCS = 1'b0;
        wait_clk(H);
        chk("busy_open", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            sif.ResSDI = v[nbits-1-i];
            wait_clk(H);
            cap[i] = sif.ResSDO;
            sif.ResClk = 1'b1;
            if (cs_last && i == nbits - 1) sif.ResCS = 1'b1;
            wait_clk(H);
            sif.ResClk = 1'b0;
        end
        wait_clk(H);
        sif.ResCS = 1'b1;
        wait_clk(H);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [31:0] cap;
        expq.push_back({1'b0, a, d});
        model[a] = d;
        send(11, {21'b0, a, d}, 1'b0, cap);
    endtask

    task automatic bad(input int nbits, input logic [31:0] v, input bit cs_last);
        logic [31:0] cap;
        expq.push_back({1'b1, 3'd0, 8'd0});
        send(nbits, v, cs_last, cap);
    endtask

    task automatic check_bus(input string tag);
        wait_clk(6);
        for (int ch = 0; ch < 8; ch++)
            chk($sformatf("%s_wiper%0d", tag, ch), wiper_bus[ch*8 +: 8], model[ch]);
        chk({tag, "_pending"}, expq.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sif.ResCS = 1'b1; sif.ResClk = 1'b0; sif.ResSDI = 1'b0;
        wait_clk(3);
        for (int ch = 0; ch < 8; ch++) model[ch] = 8'h80;
        rst_n = 1'b1;
        wait_clk(3);
    endtask

    // Monitor: every strobe or error pulse must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (wr_stb || frame_err)) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got stb=%0d err=%0d expected none", wr_stb, frame_err);
            end else begin
                e = expq.pop_front();
                chk("evt_err", frame_err, e.err);
                chk("evt_stb", wr_stb, !e.err);
                if (!e.err) begin
                    chk("evt_addr", wr_addr, e.a);
                    chk("evt_data", wr_data, e.d);
                    chk("evt_wiper", wiper_bus[int'(e.a)*8 +: 8], e.d);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        logic [7:0]  rbw;
        logic [7:0]  d_tab[6];
        d_tab = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h60, 8'hFF};

        do_reset();
        chk("rst_stb", wr_stb, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_sdo", sif.ResSDO, 0);
        check_bus("rst");

        wr(3'd5, 8'h60);
        chk("busy_after", busy, 0);
        check_bus("single");
        wait_clk(20);
        chk("hold_addr", wr_addr, 5);
        chk("hold_data", wr_data, 8'h60);

        do_reset();
        for (int a = 0; a < 6; a++) wr(3'(a), d_tab[a]);
        check_bus("b2b");

        do_reset();
        bad(10, 32'h0000_0155, 1'b0);
        bad(12, {20'b0, 3'd2, 8'h55, 1'b1}, 1'b0);
        bad(17, 32'h0001_5A5A, 1'b0);
        bad(11, {21'b0, 3'd2, 8'h77}, 1'b1);
        check_bus("badlen");

        wr(3'd1, 8'h11);
        sif.ResCS = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 5; i++) begin
            sif.ResSDI = i[0];
            wait_clk(H);
            sif.ResClk = 1'b1;
            wait_clk(H);
            sif.ResClk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(2);
        sif.ResCS = 1'b1;
        wait_clk(2);
        for (int ch = 0; ch < 8; ch++) model[ch] = 8'h80;
        rst_n = 1'b1;
        wait_clk(10);
        chk("midrst_busy", busy, 0);
        check_bus("midrst");

        wr(3'd3, 8'hA5);
        expq.push_back({1'b0, 3'd3, 8'h3C});
        send(11, {21'b0, 3'd3, 8'h3C}, 1'b0, cap);
        model[3] = 8'h3C;
        rbw = 8'hA5;
`ifdef DPOT_READBACK_EN
        for (int i = 3; i < 11; i++) chk($sformatf("sdo_bit%0d", i), cap[i], rbw[10-i]);
`else
        chk("sdo_tied", cap, 0);
        chk("sdo_word_unused", rbw, 8'hA5);
`endif
        check_bus("readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
